// File: rtl/router_sync_n_pkg.sv
// Shared defaults and helpers for the parametrised router synchronizer.
package router_pkg;

  localparam int unsigned ROUTER_NUM_PORTS = 3;
  localparam int unsigned ROUTER_ADDR_W    = 2;
  localparam int unsigned ROUTER_TIMEOUT   = 30;

  // Smallest r with 2**r >= v; used to size the timeout counters.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/router_sync_n_if.sv
// FSM/FIFO-side bus of the router synchronizer.
interface router_sync_n_if
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int unsigned ADDR_W    = ROUTER_ADDR_W
);
  logic [ADDR_W-1:0]    din;
  logic                 detect_addr;
  logic                 wr_en_reg;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] rd_en;
  logic [NUM_PORTS-1:0] wr_en;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 addr_err;

  modport master (
    output din, detect_addr, wr_en_reg, full, empty, rd_en,
    input  wr_en, fifo_full, vld_out, soft_reset, addr_err
  );

  modport slave (
    input  din, detect_addr, wr_en_reg, full, empty, rd_en,
    output wr_en, fifo_full, vld_out, soft_reset, addr_err
  );
endinterface

// File: rtl/router_sync_n_timer.sv
// Per-port idle timer: pulses soft_reset after TIMEOUT valid-but-unread cycles.
module router_sync_timer #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic soft_reset
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Any read or an empty FIFO restarts the window; the pulse also restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd_en) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end
endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the header address, steers FIFO writes,
// returns the addressed full flag and flushes ports whose data sits unread.
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int unsigned ADDR_W    = ROUTER_ADDR_W,
  parameter int unsigned TIMEOUT   = ROUTER_TIMEOUT,
  parameter int unsigned CNT_W     = clog2(TIMEOUT + 1)
) (
  input logic            clk,
  input logic            rst,
  router_sync_n_if.slave bus
);
  localparam int unsigned AW1 = ADDR_W + 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("router_sync_n: NUM_PORTS must be within 2..16");
  end
  if ((64'd1 << ADDR_W) < 64'(NUM_PORTS)) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow for NUM_PORTS");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("router_sync_n: TIMEOUT must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_bad_cnt_w
    $error("router_sync_n: CNT_W too narrow for TIMEOUT");
  end

  logic [ADDR_W-1:0]    addr_q;
  logic                 in_range;
  logic                 fifo_full_c;
  logic [NUM_PORTS-1:0] wr_en_c;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] soft_reset;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (bus.detect_addr) begin
      addr_q <= bus.din;
    end
  end

  assign in_range = ({1'b0, addr_q} < AW1'(NUM_PORTS));

  // Out-of-range addresses select nothing, so their writes are dropped.
  always_comb begin
    wr_en_c     = '0;
    fifo_full_c = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (in_range && addr_q == ADDR_W'(i)) begin
        wr_en_c[i]  = bus.wr_en_reg;
        fifo_full_c = bus.full[i];
      end
    end
  end

  assign vld = ~bus.empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld[g]),
      .rd_en      (bus.rd_en[g]),
      .soft_reset (soft_reset[g])
    );
  end

  assign bus.wr_en      = wr_en_c;
  assign bus.fifo_full  = fifo_full_c;
  assign bus.vld_out    = vld;
  assign bus.soft_reset = soft_reset;
  assign bus.addr_err   = ~in_range;
endmodule
